// File: rtl/sys_cmd_master.sv
// Host-side command initiator: serializes one request into a command byte frame on a
// byte-stream TX port, then collects the 1- or 2-byte response from RX with a timeout.
module sys_cmd_master #(
    parameter int DATA_WD     = 8,
    parameter int REG_ADDR_WD = 4,
    parameter int ALU_FUN_WD  = 4,
    parameter int ALU_OUT_WD  = 2 * DATA_WD,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [1:0]             req_cmd,
    input  logic [REG_ADDR_WD-1:0] req_addr,
    input  logic [DATA_WD-1:0]     req_wdata,
    input  logic [DATA_WD-1:0]     req_op_a,
    input  logic [DATA_WD-1:0]     req_op_b,
    input  logic [ALU_FUN_WD-1:0]  req_fun,
    output logic [DATA_WD-1:0]     tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    input  logic [DATA_WD-1:0]     rx_data,
    input  logic                   rx_valid,
    output logic [ALU_OUT_WD-1:0]  rsp_data,
    output logic                   rsp_valid,
    output logic                   rsp_timeout,
    output logic                   cmd_done
);

    localparam int CNT_WD = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // The pulse is registered, so the decision is taken one cycle before it shows.
    localparam logic [CNT_WD-1:0] CNT_TERM = CNT_WD'(TIMEOUT_CYC - 2);

    localparam logic [DATA_WD-1:0] HDR_REG_WR  = DATA_WD'(8'hAA);
    localparam logic [DATA_WD-1:0] HDR_REG_RD  = DATA_WD'(8'hBB);
    localparam logic [DATA_WD-1:0] HDR_ALU_OP  = DATA_WD'(8'hCC);
    localparam logic [DATA_WD-1:0] HDR_ALU_NOP = DATA_WD'(8'hDD);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_SEND      = 2'd1,
        ST_WAIT_RSP0 = 2'd2,
        ST_WAIT_RSP1 = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_REG_WR  = 2'd0,
        CMD_REG_RD  = 2'd1,
        CMD_ALU_OP  = 2'd2,
        CMD_ALU_NOP = 2'd3
    } cmd_t;

    state_t                  state, state_nxt;
    cmd_t                    cmd_q;
    logic [REG_ADDR_WD-1:0]  addr_q;
    logic [DATA_WD-1:0]      wdata_q;
    logic [DATA_WD-1:0]      op_a_q;
    logic [DATA_WD-1:0]      op_b_q;
    logic [ALU_FUN_WD-1:0]   fun_q;
    logic [1:0]              idx;
    logic [1:0]              last_idx;
    logic [CNT_WD-1:0]       cnt;
    logic [DATA_WD-1:0]      rsp_lo;
    logic [DATA_WD-1:0]      frame_byte;

    logic accept;
    logic tx_fire;
    logic in_wait;
    logic rsp_fin;
    logic done_wr;
    logic to_fire;
    logic cnt_clr;

    assign accept    = req_valid & req_ready;
    assign in_wait   = (state == ST_WAIT_RSP0) || (state == ST_WAIT_RSP1);
    assign req_ready = (state == ST_IDLE);
    assign tx_valid  = (state == ST_SEND);
    assign tx_data   = tx_valid ? frame_byte : '0;

    // Frame byte selection and frame length, from captured request fields only.
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        frame_byte = '0;
        last_idx   = 2'd0;
        case (cmd_q)
            CMD_REG_WR: begin
                last_idx = 2'd2;
                case (idx)
                    2'd0:    frame_byte = HDR_REG_WR;
                    2'd1:    frame_byte = DATA_WD'(addr_q);
                    default: frame_byte = wdata_q;
                endcase
            end
            CMD_REG_RD: begin
                last_idx   = 2'd1;
                frame_byte = (idx == 2'd0) ? HDR_REG_RD : DATA_WD'(addr_q);
            end
            CMD_ALU_OP: begin
                last_idx = 2'd3;
                case (idx)
                    2'd0:    frame_byte = HDR_ALU_OP;
                    2'd1:    frame_byte = op_a_q;
                    2'd2:    frame_byte = op_b_q;
                    default: frame_byte = DATA_WD'(fun_q);
                endcase
            end
            default: begin
                last_idx   = 2'd1;
                frame_byte = (idx == 2'd0) ? HDR_ALU_NOP : DATA_WD'(fun_q);
            end
        endcase
    end

    always_comb begin
        state_nxt = state;
        tx_fire   = 1'b0;
        rsp_fin   = 1'b0;
        done_wr   = 1'b0;
        to_fire   = 1'b0;
        cnt_clr   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (tx_ready) begin
                    tx_fire = 1'b1;
                    if (idx == last_idx) begin
                        if (cmd_q == CMD_REG_WR) begin
                            state_nxt = ST_IDLE;
                            done_wr   = 1'b1;
                        end else begin
                            state_nxt = ST_WAIT_RSP0;
                            cnt_clr   = 1'b1;
                        end
                    end
                end
            end
            ST_WAIT_RSP0: begin
                if (rx_valid) begin
                    cnt_clr = 1'b1;
                    if (cmd_q == CMD_REG_RD) begin
                        state_nxt = ST_IDLE;
                        rsp_fin   = 1'b1;
                    end else begin
                        state_nxt = ST_WAIT_RSP1;
                    end
                end else if (cnt == CNT_TERM) begin
                    state_nxt = ST_IDLE;
                    to_fire   = 1'b1;
                end
            end
            ST_WAIT_RSP1: begin
                if (rx_valid) begin
                    cnt_clr   = 1'b1;
                    state_nxt = ST_IDLE;
                    rsp_fin   = 1'b1;
                end else if (cnt == CNT_TERM) begin
                    state_nxt = ST_IDLE;
                    to_fire   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q   <= CMD_REG_WR;
            addr_q  <= '0;
            wdata_q <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            fun_q   <= '0;
        end else if (accept) begin
            cmd_q   <= cmd_t'(req_cmd);
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            op_a_q  <= req_op_a;
            op_b_q  <= req_op_b;
            fun_q   <= req_fun;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= 2'd0;
            cnt <= '0;
        end else begin
            if (accept)       idx <= 2'd0;
            else if (tx_fire) idx <= idx + 2'd1;

            if (cnt_clr)      cnt <= '0;
            else if (in_wait) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_lo      <= '0;
            rsp_data    <= '0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            cmd_done    <= 1'b0;
        end else begin
            if (state == ST_WAIT_RSP0 && rx_valid) rsp_lo <= rx_data;
            if (rsp_fin) begin
                if (cmd_q == CMD_REG_RD) rsp_data <= ALU_OUT_WD'(rx_data);
                else                     rsp_data <= ALU_OUT_WD'({rx_data, rsp_lo});
            end
            rsp_valid   <= rsp_fin;
            rsp_timeout <= to_fire;
            cmd_done    <= rsp_fin | done_wr | to_fire;
        end
    end

endmodule
